// File: rtl/poly_stream_if.sv
// Bundle for poly_stream_out: control pulses, BRAM read port, coefficient stream
// and the FSM state for debug/checker binding.
interface poly_stream_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [95:0] rd_data;
  // Stream: a beat transfers only in a cycle where m_valid and m_ready are both
  // high; once m_valid rises, m_valid/m_data/m_last hold until that happens.
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_last;
  logic [1:0]  state;

  modport master (
    input  start, rd_data, m_ready,
    output busy, done, rd_en, rd_addr, m_valid, m_data, m_last, state
  );

  modport slave (
    output start, rd_data, m_ready,
    input  busy, done, rd_en, rd_addr, m_valid, m_data, m_last, state
  );
endinterface

// File: rtl/poly_stream_out.sv
// Unloads one 256-coefficient polynomial (64 x 96-bit BRAM words) as a 24-bit stream.
// Optional macro POLY_STREAM_FREEZE_EN folds lane values from [0,2Q) into [0,Q).
module poly_stream_out (
  input  logic          clk,
  input  logic          rst,
  poly_stream_if.master bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [23:0] Q = 24'd8380417;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        rd_en_q;
  logic        pend_q;
  logic [5:0]  rd_addr_q;
  logic [6:0]  rd_cnt_q;
  logic [95:0] cur_q;
  logic [95:0] hold_q;
  logic        cur_valid_q;
  logic        hold_full_q;
  logic [1:0]  lane_q;
  logic [5:0]  cur_idx_q;
  logic [5:0]  load_cnt_q;

  logic        fire;
  logic        last_fire;
  logic        cur_free;
  logic        pend_to_cur;
  logic        pend_to_hold;
  logic        issue;
  logic [23:0] lane_val;
  logic [23:0] coef;

  always_comb begin
    fire         = cur_valid_q & bus.m_ready;
    last_fire    = fire & (cur_idx_q == 6'd63) & (lane_q == 2'd3);
    // Current word slot is reusable when empty or its last lane leaves this cycle.
    cur_free     = ~cur_valid_q | (fire & (lane_q == 2'd3));
    pend_to_cur  = pend_q & cur_free & ~hold_full_q;
    pend_to_hold = pend_q & ~pend_to_cur;
    // One read in flight at most, and only into an empty holding register.
    issue        = ((state_q == FILL) || (state_q == STREAM)) & ~hold_full_q &
                   ~rd_en_q & ~pend_q & ~rd_cnt_q[6];
    case (lane_q)
      2'd0:    lane_val = cur_q[23:0];
      2'd1:    lane_val = cur_q[47:24];
      2'd2:    lane_val = cur_q[71:48];
      default: lane_val = cur_q[95:72];
    endcase
  end

`ifdef POLY_STREAM_FREEZE_EN
  assign coef = (lane_val >= Q) ? (lane_val - Q) : lane_val;
`else
  assign coef = lane_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      pend_q      <= 1'b0;
      rd_addr_q   <= 6'd0;
      rd_cnt_q    <= 7'd0;
      cur_q       <= '0;
      hold_q      <= '0;
      cur_valid_q <= 1'b0;
      hold_full_q <= 1'b0;
      lane_q      <= 2'd0;
      cur_idx_q   <= 6'd0;
      load_cnt_q  <= 6'd0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      pend_q  <= rd_en_q;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= FILL;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= 6'd0;
            rd_cnt_q   <= 7'd1;
            load_cnt_q <= 6'd0;
          end
        end
        FILL: begin
          if (pend_to_cur) state_q <= STREAM;
        end
        STREAM: begin
          if (issue && (rd_cnt_q == 7'd63)) state_q <= FLUSH;
        end
        FLUSH: begin
          if (last_fire) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (issue) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= rd_cnt_q[5:0];
        rd_cnt_q  <= rd_cnt_q + 7'd1;
      end

      if (cur_free) begin
        if (hold_full_q || pend_q) begin
          cur_q       <= hold_full_q ? hold_q : bus.rd_data;
          cur_valid_q <= 1'b1;
          lane_q      <= 2'd0;
          cur_idx_q   <= load_cnt_q;
          load_cnt_q  <= load_cnt_q + 6'd1;
        end else begin
          cur_valid_q <= 1'b0;
        end
      end else if (fire) begin
        lane_q <= lane_q + 2'd1;
      end

      if (pend_to_hold) begin
        hold_q      <= bus.rd_data;
        hold_full_q <= 1'b1;
      end else if (cur_free && hold_full_q) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.m_valid = cur_valid_q;
  assign bus.m_data  = cur_valid_q ? coef : 24'd0;
  assign bus.m_last  = cur_valid_q & (cur_idx_q == 6'd63) & (lane_q == 2'd3);
  assign bus.state   = state_q;
endmodule

// File: tb/tb_poly_stream_out.sv
// Self-checking bench for poly_stream_out: BRAM model, stream scoreboard against a
// word/lane reference model, table vectors for lane folding, multi-cycle corner cases.
`timescale 1ns/1ps
module tb_poly_stream_out;
  localparam logic [23:0] Q = 24'd8380417;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_stream_if bus();
  poly_stream_out dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: coefficient i lives in word i/4, lane i%4
  logic [95:0] mem [64];
  logic [23:0] exp_q [$];

  function automatic logic [23:0] model(input logic [23:0] c);
`ifdef POLY_STREAM_FREEZE_EN
    return (c >= Q) ? c - Q : c;
`else
    return c;
`endif
  endfunction

  task automatic fill_pattern();
    for (int a = 0; a < 64; a++)
      mem[a] = {24'(4*a+3), 24'(4*a+2), 24'(4*a+1), 24'(4*a)};
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++)
      for (int l = 0; l < 4; l++)
        mem[a][24*l +: 24] = 24'($urandom_range(0, 2*int'(Q) - 1));
  endtask

  task automatic push_expected();
    for (int i = 0; i < 256; i++)
      exp_q.push_back(model(mem[i/4][24*(i%4) +: 24]));
  endtask

  // BRAM with one-cycle read latency plus address-order checking
  int rd_cnt = 0;
  int reads_total = 0;
  always @(posedge clk) begin
    if (bus.rd_en) begin
      chk("rd_addr", 96'(bus.rd_addr), 96'(rd_cnt % 64));
      bus.rd_data <= mem[bus.rd_addr];
      reads_total <= reads_total + 1;
    end
    if (rst) rd_cnt <= 0;
    else if (bus.rd_en) rd_cnt <= rd_cnt + 1;
  end

  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    bus.m_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // stream scoreboard
  int hs_idx = 0, hs_total = 0, done_total = 0, cyc = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0;
  logic done_exp = 1'b0;
  logic prev_stall = 1'b0;
  logic [23:0] prev_data = 24'd0;
  logic [23:0] got [256];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hs_idx = 0;
      done_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_pulse", 96'(bus.done), 96'(done_exp));
      if (bus.done) begin
        done_total++;
        chk("busy_at_done", 96'(bus.busy), 96'(0));
      end
      if (prev_stall) begin
        chk("stall_valid", 96'(bus.m_valid), 96'(1));
        chk("stall_data", 96'(bus.m_data), 96'(prev_data));
      end
      if (!bus.m_valid) begin
        chk("idle_data", 96'(bus.m_data), 96'(0));
        chk("idle_last", 96'(bus.m_last), 96'(0));
      end else begin
        chk("m_last", 96'(bus.m_last), 96'(hs_idx == 255));
      end
      done_exp = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        chk("busy_in_xfer", 96'(bus.busy), 96'(1));
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_hs: got %0d expected no transfer", bus.m_data);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            failures++;
            $display("FAIL m_data[%0d]: got %0d expected %0d", hs_idx, bus.m_data, e);
          end
        end
        got[hs_idx] = bus.m_data;
        if (hs_idx == 0) first_hs_cyc = cyc;
        if (hs_idx == 255) begin
          last_hs_cyc = cyc;
          done_exp = 1'b1;
        end
        hs_idx = (hs_idx + 1) % 256;
        hs_total++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  task automatic start_measure(output int lat);
    lat = 99;
    bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.m_valid && lat == 99) lat = k;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_total < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 96'(done_total >= target), 96'(1));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"},    96'(bus.busy),    96'(0));
    chk({name, "_done"},    96'(bus.done),    96'(0));
    chk({name, "_rd_en"},   96'(bus.rd_en),   96'(0));
    chk({name, "_rd_addr"}, 96'(bus.rd_addr), 96'(0));
    chk({name, "_m_valid"}, 96'(bus.m_valid), 96'(0));
    chk({name, "_m_data"},  96'(bus.m_data),  96'(0));
    chk({name, "_m_last"},  96'(bus.m_last),  96'(0));
    chk({name, "_state"},   96'(bus.state),   96'(0));
  endtask

  typedef struct {
    int          idx;
    logic [23:0] lane_in;
    logic [23:0] exp_out;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, h0, r0, d0, n;

`ifdef POLY_STREAM_FREEZE_EN
    tbl[0] = '{0,   24'd8380417,  24'd0};
    tbl[1] = '{1,   24'd8380418,  24'd1};
    tbl[2] = '{2,   24'd8380416,  24'd8380416};
    tbl[3] = '{3,   24'd0,        24'd0};
    tbl[4] = '{4,   24'd16760833, 24'd8380416};
    tbl[5] = '{255, 24'd16000000, 24'd7619583};
`else
    tbl[0] = '{0,   24'd8380417,  24'd8380417};
    tbl[1] = '{1,   24'd8380418,  24'd8380418};
    tbl[2] = '{2,   24'd8380416,  24'd8380416};
    tbl[3] = '{3,   24'd0,        24'd0};
    tbl[4] = '{4,   24'd16760833, 24'd16760833};
    tbl[5] = '{255, 24'd16000000, 24'd16000000};
`endif

    bus.start = 1'b0;
    ready_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // streaming at full rate
    fill_pattern(); push_expected();
    h0 = hs_total; r0 = reads_total; d0 = done_total;
    start_measure(lat);
    chk("A_first_valid_latency_le3", 96'(lat <= 3), 96'(1));
    wait_done(d0 + 1, 600, "A_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("A_handshakes", 96'(hs_total - h0), 96'(256));
    chk("A_consecutive_cycles", 96'(last_hs_cyc - first_hs_cyc), 96'(255));
    chk("A_reads", 96'(reads_total - r0), 96'(64));
    chk("A_single_done", 96'(done_total - d0), 96'(1));
    chk("A_busy_after", 96'(bus.busy), 96'(0));

    // random back-pressure, random lane data
    fill_random(); push_expected();
    ready_pct = 30;
    h0 = hs_total; r0 = reads_total; d0 = done_total;
    start_measure(lat);
    wait_done(d0 + 1, 4000, "B_done_timeout");
    ready_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    chk("B_handshakes", 96'(hs_total - h0), 96'(256));
    chk("B_reads", 96'(reads_total - r0), 96'(64));
    chk("B_queue_empty", 96'(exp_q.size()), 96'(0));

    // reset in the middle of a transfer
    fill_pattern(); push_expected();
    d0 = done_total;
    start_measure(lat);
    n = 0;
    while (hs_idx < 100 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("C_reach_hs100", 96'(hs_idx >= 100), 96'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("C_abort");
    rst = 1'b0;
    exp_q.delete();
    repeat (8) @(posedge clk);
    #1;
    chk("C_no_done", 96'(done_total - d0), 96'(0));
    chk("C_idle_after", 96'(bus.busy), 96'(0));
    push_expected();
    h0 = hs_total; r0 = reads_total;
    start_measure(lat);
    wait_done(d0 + 1, 600, "C_restart_done_timeout");
    repeat (2) @(posedge clk);
    #1;
    chk("C_restart_handshakes", 96'(hs_total - h0), 96'(256));
    chk("C_restart_reads", 96'(reads_total - r0), 96'(64));

    // start during STREAM must be ignored
    push_expected();
    h0 = hs_total; d0 = done_total;
    start_measure(lat);
    repeat (20) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(d0 + 1, 600, "D_done_timeout");
    repeat (10) @(posedge clk);
    #1;
    chk("D_handshakes", 96'(hs_total - h0), 96'(256));
    chk("D_single_done", 96'(done_total - d0), 96'(1));
    chk("D_not_restarted", 96'(bus.busy), 96'(0));

    // table vectors: lane folding at the Q boundary
    fill_random();
    foreach (tbl[i]) mem[tbl[i].idx/4][24*(tbl[i].idx%4) +: 24] = tbl[i].lane_in;
    push_expected();
    d0 = done_total;
    start_measure(lat);
    wait_done(d0 + 1, 600, "F_done_timeout");
    for (int i = 0; i < 6; i++)
      chk($sformatf("F_lane_value_idx%0d", tbl[i].idx), 96'(got[tbl[i].idx]), 96'(tbl[i].exp_out));

    // back-to-back polynomials, second start in the done cycle
    fill_pattern(); push_expected(); push_expected();
    h0 = hs_total; r0 = reads_total; d0 = done_total;
    start_measure(lat);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 600);
    chk("E_first_done_seen", 96'(bus.done), 96'(1));
    bus.start = 1'b1;
    lat = 99;
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.m_valid && lat == 99) lat = k;
    end
    chk("E_second_latency_le3", 96'(lat <= 3), 96'(1));
    wait_done(d0 + 2, 600, "E_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("E_handshakes", 96'(hs_total - h0), 96'(512));
    chk("E_reads", 96'(reads_total - r0), 96'(128));
    chk("E_done_count", 96'(done_total - d0), 96'(2));
    chk("E_queue_empty", 96'(exp_q.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
